// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode queue.
package fetch_queue_pkg;

  localparam int FQ_PC_W    = 32;
  localparam int FQ_INSTR_W = 32;

  localparam logic [FQ_PC_W-1:0] FQ_RESET_PC = 32'h0;

  typedef struct packed {
    logic [FQ_PC_W-1:0]    pc;
    logic [FQ_INSTR_W-1:0] instr;
  } fq_entry_t;

  function automatic logic [FQ_PC_W-1:0] fq_pc_plus4(input logic [FQ_PC_W-1:0] pc);
    return pc + FQ_PC_W'(4);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/ROM/decode signal bundle for fetch_queue; slave is the queue side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  import fetch_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [FQ_PC_W-1:0]    fetch_pc;
  logic [FQ_INSTR_W-1:0] imem_rdata;
  logic                  redirect;
  logic                  dec_ready;
  logic                  fetch_en;
  logic                  dec_valid;
  logic [FQ_PC_W-1:0]    dec_pc;
  logic [FQ_INSTR_W-1:0] dec_instr;
  logic [FQ_PC_W-1:0]    dec_pc_p4;
  logic [PTR_W:0]        count;

  modport master (
    output fetch_pc, imem_rdata, redirect, dec_ready,
    input  fetch_en, dec_valid, dec_pc, dec_instr, dec_pc_p4, count
  );

  modport slave (
    input  fetch_pc, imem_rdata, redirect, dec_ready,
    output fetch_en, dec_valid, dec_pc, dec_instr, dec_pc_p4, count
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one write port, one asynchronous read port.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  fq_entry_t        wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output fq_entry_t        rd_data
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between instruction fetch and decode with redirect flush.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a return straight to decode when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);

  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     cnt;
  logic               inflight;
  logic [FQ_PC_W-1:0] inflight_pc;
  logic [PTR_W+1:0]   credit;
  logic               empty, issue, bypass, push, pop;
  fq_entry_t          wr_entry, head;

  always_comb begin
    empty    = (cnt == '0);
    credit   = {1'b0, cnt} + {{(PTR_W+1){1'b0}}, inflight};
    // Credit counts the outstanding ROM read but not a same-cycle pop.
    issue    = rst & (bus.redirect | (credit < (PTR_W+2)'(DEPTH)));
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass   = empty & inflight & ~bus.redirect;
`else
    bypass   = 1'b0;
`endif
    pop      = ~empty & bus.dec_ready;
    push     = inflight & ~bus.redirect & ~(bypass & bus.dec_ready);
    wr_entry = '{pc: inflight_pc, instr: bus.imem_rdata};
  end

  fetch_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_entry),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      inflight    <= 1'b0;
      inflight_pc <= FQ_RESET_PC;
    end else begin
      inflight <= issue & ~bus.redirect;
      if (issue & ~bus.redirect) inflight_pc <= bus.fetch_pc;
      if (bus.redirect) begin
        cnt    <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      cnt <= cnt + (PTR_W+1)'(1);
        else if (pop && !push) cnt <= cnt - (PTR_W+1)'(1);
      end
    end
  end

  always_comb begin
    bus.fetch_en  = issue;
    bus.dec_valid = ~empty | bypass;
    bus.count     = cnt;
    bus.dec_pc    = '0;
    bus.dec_instr = '0;
    bus.dec_pc_p4 = '0;
    if (bypass) begin
      bus.dec_pc    = inflight_pc;
      bus.dec_instr = bus.imem_rdata;
      bus.dec_pc_p4 = fq_pc_plus4(inflight_pc);
    end else if (!empty) begin
      bus.dec_pc    = head.pc;
      bus.dec_instr = head.instr;
      bus.dec_pc_p4 = fq_pc_plus4(head.pc);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    push |-> (cnt != (PTR_W+1)'(DEPTH)));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between instruction fetch and decode.
- Captures each PC issued to the synchronous instruction ROM, pairs it with the returned instruction word one cycle later, and holds up to DEPTH {pc, instr} entries.
- Drives the PC register enable, so fetch stalls on back-pressure.
- Discards all wrong-path work on a redirect (j / jr / taken branch) resolved in decode.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- fetch_pc  in  32  current PC register output, also ROM address this cycle.
- imem_rdata  in  32  ROM read data for the address presented in the previous cycle.
- redirect  in  1  decode resolved a j/jr/taken branch this cycle.
- dec_ready  in  1  decode accepts the head entry.
- fetch_en  out  1  PC register enable.
- dec_valid  out  1  head entry valid.
- dec_pc  out  32  head entry PC.
- dec_instr  out  32  head entry instruction.
- dec_pc_p4  out  32  dec_pc + 4, modulo 2^32.
- count  out  PTR_W+1  occupied entries.

Behaviour:
- Reset (rst==0 at posedge):
  - count=0, pointers=0, inflight=0.
  - dec_valid=0; dec_pc / dec_instr / dec_pc_p4 = 0.
  - fetch_en=0 while rst==0.
- Issue: fetch_en = redirect | (count + inflight < DEPTH).
  - Conservative credit: a same-cycle pop is not counted.
  - On an issue cycle without redirect: inflight<=1, inflight_pc<=fetch_pc.
  - Otherwise inflight<=0.
- Return: when inflight==1, the cycle's imem_rdata belongs to inflight_pc.
  - Without redirect, {inflight_pc, imem_rdata} is pushed at the tail.
  - Credit rule guarantees the push never overflows. Assert count<DEPTH on push.
- Pop: occurs when dec_valid & dec_ready; head advances.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged.
  - When count==1, the new entry becomes the head next cycle.
- Redirect:
  - Queue cleared: count<=0, rd_ptr<=wr_ptr.
  - Any returning in-flight word is dropped, and so is the ROM read for fetch_pc in this cycle.
  - fetch_en=1, so the PC register loads the target.
  - The first target instruction is pushed 2 cycles after redirect and becomes visible on the 3rd cycle.
- dec_valid = (count != 0). Head outputs are registered storage reads, not a combinational path from imem_rdata (see optional feature).
- Empty: pop is ignored. dec_ready is don't-care.
- Full: count==DEPTH → fetch_en=0 unless redirect. The PC register holds, so the same address is re-read and that data is ignored (inflight=0).
- Reset asserted mid-operation has priority over redirect, push and pop.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0 and a valid return arrives (inflight & ~redirect), the return is forwarded combinationally.
  - dec_valid=1, dec_pc=inflight_pc, dec_instr=imem_rdata.
  - If dec_ready, the return is consumed without a push.
  - Zero added latency: the fetch-to-decode path is 1 cycle (ROM latency only).
- Undefined: every return is pushed first and visible the next cycle, adding 1 cycle of fetch-to-decode latency. There is no combinational path from imem_rdata to the outputs.

Decomposition:
- Package fetch_queue_pkg:
  - FQ_PC_W=32, FQ_INSTR_W=32.
  - Entry typedef {pc, instr}.
  - Reset constant FQ_RESET_PC=32'h0.
- Sub-module fetch_queue_mem:
  - DEPTH x 64-bit register array.
  - One write port and one asynchronous read port, indexed by wr_ptr/rd_ptr.
  - Keeps pointer/credit control separate from storage.

Test Plan:
- Reset/streaming:
  - Stimulus: release rst with dec_ready=1 and ROM returning instr=addr.
  - Response without bypass: dec_pc steps 0,4,8,... one per cycle after a 2-cycle fill, with dec_instr==dec_pc and dec_pc_p4==dec_pc+4.
- Back-pressure:
  - Stimulus: dec_ready=0 for 10 cycles.
  - Response: count saturates at 4 and fetch_en=0. When ready returns, entries 0,4,8,12 drain in order with no gap, duplicate or loss.
- Redirect mid-stream:
  - Stimulus: queue holds 3 entries plus one in flight; pulse redirect with PC loaded to 0x100.
  - Response: next cycle count=0 and dec_valid=0. The next dec_pc is 0x100 with no stale word; the in-flight word is dropped.
- Redirect on a full queue with pop:
  - Stimulus: count=4, dec_ready=1 and redirect in the same cycle.
  - Response: fetch_en=1, queue empties, no underflow or overflow assertion fires.
- Pointer wrap:
  - Stimulus: 37 pushes/pops with random dec_ready.
  - Response: the sequence matches a scoreboard across multiple wraps, and count never exceeds 4.
- Bypass build:
  - Stimulus: FETCH_QUEUE_BYPASS_EN defined, empty queue, dec_ready=1.
  - Response: dec_valid is high in the same cycle imem_rdata arrives, and count stays 0.
